// File: rtl/punc_controller.sv
// ============================================================================
// punc_controller
// ----------------------------------------------------------------------------
// Control FSM for the PUnC LC3 datapath.
//
// The controller fetches each instruction into IR, decodes ir[15:12], and
// drives the datapath strobes for one execute cycle. LDI and STI use two
// execute cycles. The HALT opcode locks the controller in the HALT state.
//
// The only architectural state held here is the FSM state register. Every
// output is decoded combinationally from that state and from the ir and
// nzp_true inputs.
//
// Build option:
//   PUNC_LEA_CC_EN  When defined, LEA loads the condition codes (classic LC3
//                   behaviour). When undefined, LEA leaves NZP untouched.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset (forces INIT)
//   ir[15:0]            current IR contents from the datapath
//   nzp_true            branch condition evaluated by the datapath
//   pc_ld/clr/inc       PC load, clear and increment strobes
//   pc_sel[1:0]         PC source: 0 PC+sext9, 1 PC+sext11, 2 R1 data
//   ir_ld/ir_clr        IR load and clear strobes
//   mem_rd/mem_wr       memory read and write strobes
//   mem_r_addr_sel[1:0] read address: 0 PC, 1 PC+sext9, 2 R0, 3 R1+sext6
//   mem_w_addr_sel[1:0] write address: 0 PC+sext9, 1 prev, 2 R1+sext6
//   rf_w_data_sel[1:0]  RF write data: 0 ALU, 1 PC+sext9, 2 mem data, 3 PC
//   rf_w_addr_sel       RF write address: 0 R7, 1 ir[11:9]
//   rf_w_wr             RF write enable
//   rf_r0_addr_sel      R0 read address: 0 ir[11:9], 1 ir[2:0]
//   rf_r0_rd/rf_r1_rd   RF read strobes
//   prev_ld             load prev register from memory read data
//   nzp_ld/nzp_clr      condition-code load and clear
//   alu_sel[1:0]        ALU op: 0 PassA, 1 ADD, 2 AND, 3 NOT
//   alu_first_val_sel   ALU first operand: 0 sext(ir[4:0]), 1 R0 data
//   halted              high while in HALT
//   state_debug[2:0]    current state encoding
// ============================================================================
module punc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        nzp_true,

    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_sel,

    output logic        ir_ld,
    output logic        ir_clr,

    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_r_addr_sel,
    output logic [1:0]  mem_w_addr_sel,

    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        rf_w_wr,
    output logic        rf_r0_addr_sel,
    output logic        rf_r0_rd,
    output logic        rf_r1_rd,

    output logic        prev_ld,

    output logic        nzp_ld,
    output logic        nzp_clr,

    output logic [1:0]  alu_sel,
    output logic        alu_first_val_sel,

    output logic        halted,
    output logic [2:0]  state_debug
);

    // ------------------------------------------------------------------------
    // State encoding. Codes 5-7 are illegal and recover to INIT.
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Opcodes (ir[15:12])
    // ------------------------------------------------------------------------
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // ------------------------------------------------------------------------
    // Mux select encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] PC_SEL_OFF9  = 2'd0;
    localparam logic [1:0] PC_SEL_OFF11 = 2'd1;
    localparam logic [1:0] PC_SEL_R1    = 2'd2;

    localparam logic [1:0] MEM_R_PC     = 2'd0;
    localparam logic [1:0] MEM_R_OFF9   = 2'd1;
    localparam logic [1:0] MEM_R_R0     = 2'd2;
    localparam logic [1:0] MEM_R_R1OFF6 = 2'd3;

    localparam logic [1:0] MEM_W_OFF9   = 2'd0;
    localparam logic [1:0] MEM_W_PREV   = 2'd1;
    localparam logic [1:0] MEM_W_R1OFF6 = 2'd2;

    localparam logic [1:0] RF_D_ALU     = 2'd0;
    localparam logic [1:0] RF_D_OFF9    = 2'd1;
    localparam logic [1:0] RF_D_MEM     = 2'd2;
    localparam logic [1:0] RF_D_PC      = 2'd3;

    localparam logic       RF_A_R7      = 1'b0;
    localparam logic       RF_A_DR      = 1'b1;

    localparam logic       R0_A_DR      = 1'b0;
    localparam logic       R0_A_SR2     = 1'b1;

    localparam logic [1:0] ALU_ADD      = 2'd1;
    localparam logic [1:0] ALU_AND      = 2'd2;
    localparam logic [1:0] ALU_NOT      = 2'd3;

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;

    assign opcode = ir[15:12];

    // The offsets and register fields of ir are consumed by the datapath.
    // Only the opcode, ir[11] (JSR mode) and ir[5] (immediate mode) matter here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[10:6], ir[4:0]};

    // ------------------------------------------------------------------------
    // State register. Reset acts asynchronously, so INIT outputs appear as
    // soon as rst rises. A pending EXEC2 write is dropped at that point.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = ST_INIT;
        case (state)
            ST_INIT:  state_next = ST_FETCH;
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_LDI, OP_STI: state_next = ST_EXEC2;
                    OP_HALT:        state_next = ST_HALT;
                    default:        state_next = ST_FETCH;
                endcase
            end
            ST_EXEC2: state_next = ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode. Every strobe and select defaults to 0.
    // ------------------------------------------------------------------------
    always_comb begin
        pc_ld             = 1'b0;
        pc_clr            = 1'b0;
        pc_inc            = 1'b0;
        pc_sel            = PC_SEL_OFF9;
        ir_ld             = 1'b0;
        ir_clr            = 1'b0;
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        mem_r_addr_sel    = MEM_R_PC;
        mem_w_addr_sel    = MEM_W_OFF9;
        rf_w_data_sel     = RF_D_ALU;
        rf_w_addr_sel     = RF_A_R7;
        rf_w_wr           = 1'b0;
        rf_r0_addr_sel    = R0_A_DR;
        rf_r0_rd          = 1'b0;
        rf_r1_rd          = 1'b0;
        prev_ld           = 1'b0;
        nzp_ld            = 1'b0;
        nzp_clr           = 1'b0;
        alu_sel           = 2'd0;
        alu_first_val_sel = 1'b0;
        halted            = 1'b0;

        case (state)
            ST_INIT: begin
                pc_clr  = 1'b1;
                ir_clr  = 1'b1;
                nzp_clr = 1'b1;
            end

            ST_FETCH: begin
                mem_rd         = 1'b1;
                mem_r_addr_sel = MEM_R_PC;
                ir_ld          = 1'b1;
                pc_inc         = 1'b1;
            end

            ST_EXEC: begin
                case (opcode)
                    OP_ADD, OP_AND: begin
                        rf_r1_rd          = 1'b1;
                        rf_w_wr           = 1'b1;
                        rf_w_addr_sel     = RF_A_DR;
                        rf_w_data_sel     = RF_D_ALU;
                        alu_sel           = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
                        // ir[5]=1 selects the 5-bit immediate, so SR2 is not read.
                        alu_first_val_sel = ~ir[5];
                        rf_r0_addr_sel    = R0_A_SR2;
                        rf_r0_rd          = ~ir[5];
                        nzp_ld            = 1'b1;
                    end

                    OP_NOT: begin
                        alu_sel       = ALU_NOT;
                        rf_r1_rd      = 1'b1;
                        rf_w_wr       = 1'b1;
                        rf_w_addr_sel = RF_A_DR;
                        rf_w_data_sel = RF_D_ALU;
                        nzp_ld        = 1'b1;
                    end

                    OP_BR: begin
                        if (nzp_true) begin
                            pc_ld  = 1'b1;
                            pc_sel = PC_SEL_OFF9;
                        end
                    end

                    OP_JMP: begin
                        rf_r1_rd = 1'b1;
                        pc_ld    = 1'b1;
                        pc_sel   = PC_SEL_R1;
                    end

                    OP_JSR: begin
                        // R7 and PC update on the same edge. R7 takes the
                        // pre-jump PC and JSRR reads the pre-write base register.
                        rf_w_wr       = 1'b1;
                        rf_w_addr_sel = RF_A_R7;
                        rf_w_data_sel = RF_D_PC;
                        pc_ld         = 1'b1;
                        if (ir[11]) begin
                            pc_sel = PC_SEL_OFF11;
                        end else begin
                            pc_sel   = PC_SEL_R1;
                            rf_r1_rd = 1'b1;
                        end
                    end

                    OP_LD: begin
                        mem_rd         = 1'b1;
                        mem_r_addr_sel = MEM_R_OFF9;
                        rf_w_wr        = 1'b1;
                        rf_w_addr_sel  = RF_A_DR;
                        rf_w_data_sel  = RF_D_MEM;
                        nzp_ld         = 1'b1;
                    end

                    OP_LDR: begin
                        mem_rd         = 1'b1;
                        mem_r_addr_sel = MEM_R_R1OFF6;
                        rf_r1_rd       = 1'b1;
                        rf_w_wr        = 1'b1;
                        rf_w_addr_sel  = RF_A_DR;
                        rf_w_data_sel  = RF_D_MEM;
                        nzp_ld         = 1'b1;
                    end

                    OP_LEA: begin
                        rf_w_wr       = 1'b1;
                        rf_w_addr_sel = RF_A_DR;
                        rf_w_data_sel = RF_D_OFF9;
`ifdef PUNC_LEA_CC_EN
                        nzp_ld        = 1'b1;
`else
                        nzp_ld        = 1'b0;
`endif
                    end

                    OP_ST: begin
                        mem_wr         = 1'b1;
                        mem_w_addr_sel = MEM_W_OFF9;
                        rf_r0_addr_sel = R0_A_DR;
                        rf_r0_rd       = 1'b1;
                    end

                    OP_STR: begin
                        mem_wr         = 1'b1;
                        mem_w_addr_sel = MEM_W_R1OFF6;
                        rf_r0_addr_sel = R0_A_DR;
                        rf_r0_rd       = 1'b1;
                        rf_r1_rd       = 1'b1;
                    end

                    OP_LDI: begin
                        // First hop: stage the pointer in DR. The second hop
                        // reads through it in EXEC2.
                        mem_rd         = 1'b1;
                        mem_r_addr_sel = MEM_R_OFF9;
                        rf_w_wr        = 1'b1;
                        rf_w_addr_sel  = RF_A_DR;
                        rf_w_data_sel  = RF_D_MEM;
                    end

                    OP_STI: begin
                        // Stage the pointer in prev for the EXEC2 write.
                        mem_rd         = 1'b1;
                        mem_r_addr_sel = MEM_R_OFF9;
                        prev_ld        = 1'b1;
                    end

                    OP_HALT, OP_RTI, OP_RSV: begin
                        // No datapath activity.
                    end

                    default: begin
                    end
                endcase
            end

            ST_EXEC2: begin
                if (opcode == OP_LDI) begin
                    rf_r0_addr_sel = R0_A_DR;
                    rf_r0_rd       = 1'b1;
                    mem_rd         = 1'b1;
                    mem_r_addr_sel = MEM_R_R0;
                    rf_w_wr        = 1'b1;
                    rf_w_addr_sel  = RF_A_DR;
                    rf_w_data_sel  = RF_D_MEM;
                    nzp_ld         = 1'b1;
                end else if (opcode == OP_STI) begin
                    mem_wr         = 1'b1;
                    mem_w_addr_sel = MEM_W_PREV;
                    rf_r0_addr_sel = R0_A_DR;
                    rf_r0_rd       = 1'b1;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

    assign state_debug = state;

endmodule

// File: tb/tb_punc_controller.sv
// ============================================================================
// tb_punc_controller
// ----------------------------------------------------------------------------
// Randomized scoreboard bench for punc_controller.
//
// The stimulus process advances an instruction-level model of the sequencer
// each cycle. It drives a random instruction and branch condition, and
// sometimes applies an asynchronous reset mid-cycle. It then queues the
// strobe set that the current step of that instruction should present.
//
// A separate monitor pops one expectation per falling edge and compares it
// with the DUT outputs. The monitor also checks the two exclusivity
// invariants on every cycle.
// ============================================================================
module tb_punc_controller;

    // Instruction-phase names used by the model (equal to state_debug codes)
    localparam int PH_INIT  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_EXEC2 = 3;
    localparam int PH_HALT  = 4;

`ifdef PUNC_LEA_CC_EN
    localparam bit LEA_SETS_CC = 1'b1;
`else
    localparam bit LEA_SETS_CC = 1'b0;
`endif

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] mem_r_addr_sel;
        logic [1:0] mem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_r0_addr_sel;
        logic       rf_r0_rd;
        logic       rf_r1_rd;
        logic       prev_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_first_val_sel;
        logic       halted;
        logic [2:0] state_debug;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        nzp_true = 1'b0;

    logic        pc_ld, pc_clr, pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld, ir_clr;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel;
    logic        rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd;
    logic        prev_ld, nzp_ld, nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_first_val_sel, halted;
    logic [2:0]  state_debug;

    ctrl_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Model state, owned by the stimulus process
    int    phase       = PH_INIT;
    int    rst_left    = 2;
    int    halt_cycles = 0;
    bit    first_instr = 1'b1;

    punc_controller dut (
        .clk               (clk),
        .rst               (rst),
        .ir                (ir),
        .nzp_true          (nzp_true),
        .pc_ld             (pc_ld),
        .pc_clr            (pc_clr),
        .pc_inc            (pc_inc),
        .pc_sel            (pc_sel),
        .ir_ld             (ir_ld),
        .ir_clr            (ir_clr),
        .mem_rd            (mem_rd),
        .mem_wr            (mem_wr),
        .mem_r_addr_sel    (mem_r_addr_sel),
        .mem_w_addr_sel    (mem_w_addr_sel),
        .rf_w_data_sel     (rf_w_data_sel),
        .rf_w_addr_sel     (rf_w_addr_sel),
        .rf_w_wr           (rf_w_wr),
        .rf_r0_addr_sel    (rf_r0_addr_sel),
        .rf_r0_rd          (rf_r0_rd),
        .rf_r1_rd          (rf_r1_rd),
        .prev_ld           (prev_ld),
        .nzp_ld            (nzp_ld),
        .nzp_clr           (nzp_clr),
        .alu_sel           (alu_sel),
        .alu_first_val_sel (alu_first_val_sel),
        .halted            (halted),
        .state_debug       (state_debug)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model. Each instruction is described by the register
    // transfers it performs in each of its steps.
    // ------------------------------------------------------------------------
    function automatic ctrl_t writeDr(input ctrl_t c, input logic [1:0] src);
        ctrl_t r;
        r               = c;
        r.rf_w_wr       = 1'b1;
        r.rf_w_addr_sel = 1'b1;
        r.rf_w_data_sel = src;
        return r;
    endfunction

    function automatic int nextPhase(input int ph, input logic [15:0] instr);
        logic [3:0] op;
        op = instr[15:12];
        if (ph == PH_INIT)  return PH_FETCH;
        if (ph == PH_FETCH) return PH_EXEC;
        if (ph == PH_EXEC) begin
            if (op == 4'hA || op == 4'hB) return PH_EXEC2;
            if (op == 4'hF) return PH_HALT;
            return PH_FETCH;
        end
        if (ph == PH_EXEC2) return PH_FETCH;
        if (ph == PH_HALT)  return PH_HALT;
        return PH_INIT;
    endfunction

    function automatic ctrl_t modelOutputs(input int ph, input logic [15:0] instr,
                                           input logic cond);
        ctrl_t      c;
        logic [3:0] op;
        c = '0;
        op = instr[15:12];
        c.state_debug = 3'(ph);
        if (ph == PH_INIT) begin
            c.pc_clr = 1'b1; c.ir_clr = 1'b1; c.nzp_clr = 1'b1;
        end else if (ph == PH_FETCH) begin
            c.mem_rd = 1'b1; c.ir_ld = 1'b1; c.pc_inc = 1'b1;
        end else if (ph == PH_HALT) begin
            c.halted = 1'b1;
        end else if (ph == PH_EXEC2) begin
            if (op == 4'hA) begin
                c = writeDr(c, 2'd2);
                c.mem_rd = 1'b1; c.mem_r_addr_sel = 2'd2;
                c.rf_r0_rd = 1'b1; c.nzp_ld = 1'b1;
            end else begin
                c.mem_wr = 1'b1; c.mem_w_addr_sel = 2'd1; c.rf_r0_rd = 1'b1;
            end
        end else begin
            case (op)
                4'h1, 4'h5: begin
                    c = writeDr(c, 2'd0);
                    c.alu_sel = (op == 4'h1) ? 2'd1 : 2'd2;
                    c.rf_r1_rd = 1'b1;
                    c.rf_r0_addr_sel = 1'b1;
                    if (!instr[5]) begin
                        c.rf_r0_rd = 1'b1;
                        c.alu_first_val_sel = 1'b1;
                    end
                    c.nzp_ld = 1'b1;
                end
                4'h9: begin
                    c = writeDr(c, 2'd0);
                    c.alu_sel = 2'd3; c.rf_r1_rd = 1'b1; c.nzp_ld = 1'b1;
                end
                4'h0: if (cond) c.pc_ld = 1'b1;
                4'hC: begin
                    c.rf_r1_rd = 1'b1; c.pc_ld = 1'b1; c.pc_sel = 2'd2;
                end
                4'h4: begin
                    c.rf_w_wr = 1'b1; c.rf_w_data_sel = 2'd3; c.pc_ld = 1'b1;
                    if (instr[11]) c.pc_sel = 2'd1;
                    else begin c.pc_sel = 2'd2; c.rf_r1_rd = 1'b1; end
                end
                4'h2: begin
                    c = writeDr(c, 2'd2);
                    c.mem_rd = 1'b1; c.mem_r_addr_sel = 2'd1; c.nzp_ld = 1'b1;
                end
                4'h6: begin
                    c = writeDr(c, 2'd2);
                    c.mem_rd = 1'b1; c.mem_r_addr_sel = 2'd3;
                    c.rf_r1_rd = 1'b1; c.nzp_ld = 1'b1;
                end
                4'hE: begin
                    c = writeDr(c, 2'd1);
                    c.nzp_ld = LEA_SETS_CC;
                end
                4'h3: begin
                    c.mem_wr = 1'b1; c.rf_r0_rd = 1'b1;
                end
                4'h7: begin
                    c.mem_wr = 1'b1; c.mem_w_addr_sel = 2'd2;
                    c.rf_r0_rd = 1'b1; c.rf_r1_rd = 1'b1;
                end
                4'hA: begin
                    c = writeDr(c, 2'd2);
                    c.mem_rd = 1'b1; c.mem_r_addr_sel = 2'd1;
                end
                4'hB: begin
                    c.mem_rd = 1'b1; c.mem_r_addr_sel = 2'd1; c.prev_ld = 1'b1;
                end
                default: begin
                end
            endcase
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // One clock cycle of stimulus. Advance the model past the rising edge,
    // pick new inputs, optionally pulse reset, then queue the expectation.
    // ------------------------------------------------------------------------
    task automatic applyStimulus();
        bit do_rst;
        @(posedge clk);
        #1;
        if (rst) begin
            phase = PH_INIT;
            if (rst_left > 0) rst_left--;
            else rst = 1'b0;
        end else begin
            phase = nextPhase(phase, ir);
        end
        halt_cycles = (phase == PH_HALT) ? halt_cycles + 1 : 0;

        if (phase == PH_FETCH) begin
            if (first_instr) ir = 16'hF025;
            else ir = 16'($urandom());
            first_instr = 1'b0;
        end
        nzp_true = 1'($urandom_range(0, 1));

        do_rst = 1'b0;
        if (!rst) begin
            if (phase == PH_EXEC2 && $urandom_range(0, 1) == 0) do_rst = 1'b1;
            else if (halt_cycles >= 3) do_rst = 1'b1;
            else if ($urandom_range(0, 49) == 0) do_rst = 1'b1;
        end
        if (do_rst) begin
            #2;
            rst = 1'b1;
            rst_left = $urandom_range(0, 1);
            phase = PH_INIT;
        end

        exp_q.push_back(modelOutputs(phase, ir, nzp_true));
    endtask

    // ------------------------------------------------------------------------
    // Monitor side: compare one presented output set against its expectation.
    // ------------------------------------------------------------------------
    task automatic checkOutput(input ctrl_t want);
        ctrl_t act;
        act.pc_ld             = pc_ld;
        act.pc_clr            = pc_clr;
        act.pc_inc            = pc_inc;
        act.pc_sel            = pc_sel;
        act.ir_ld             = ir_ld;
        act.ir_clr            = ir_clr;
        act.mem_rd            = mem_rd;
        act.mem_wr            = mem_wr;
        act.mem_r_addr_sel    = mem_r_addr_sel;
        act.mem_w_addr_sel    = mem_w_addr_sel;
        act.rf_w_data_sel     = rf_w_data_sel;
        act.rf_w_addr_sel     = rf_w_addr_sel;
        act.rf_w_wr           = rf_w_wr;
        act.rf_r0_addr_sel    = rf_r0_addr_sel;
        act.rf_r0_rd          = rf_r0_rd;
        act.rf_r1_rd          = rf_r1_rd;
        act.prev_ld           = prev_ld;
        act.nzp_ld            = nzp_ld;
        act.nzp_clr           = nzp_clr;
        act.alu_sel           = alu_sel;
        act.alu_first_val_sel = alu_first_val_sel;
        act.halted            = halted;
        act.state_debug       = state_debug;

        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("[TB] FAIL outputs t=%0t ir=%h nzp_true=%b: got %h expected %h (state got %0d expected %0d)",
                     $time, ir, nzp_true, act, want, act.state_debug, want.state_debug);
        end

        vectors++;
        if ((pc_inc && pc_ld) || (mem_wr && rf_w_wr)) begin
            miscompares++;
            $display("[TB] FAIL exclusivity t=%0t: got pc_inc=%b pc_ld=%b mem_wr=%b rf_w_wr=%b, expected no pair both high",
                     $time, pc_inc, pc_ld, mem_wr, rf_w_wr);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        $display("[TB] punc_controller randomized scoreboard run");
        repeat (3000) applyStimulus();
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/punc_controller.md
# punc_controller

Control FSM that sequences the PUnC LC3 datapath. It fetches each instruction into IR and decodes `ir[15:12]`. It then drives every datapath load, clear, write and mux-select strobe for one or two execute cycles, and latches into a halt state on HALT. It sits beside the datapath in the PUnC top level: it reads back only `ir` and `nzp_true`, and it owns no architectural state except its own state register.

## Interface
- No parameters.
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `ir` in 16: current IR contents from the datapath.
- `nzp_true` in 1: branch condition, `(ir[11]&n)|(ir[10]&z)|(ir[9]&p)`.
- `pc_ld`, `pc_clr`, `pc_inc` out 1: PC load, clear and increment strobes.
- `pc_sel` out 2: PC source. 0 = PC+sext(ir[8:0]), 1 = PC+sext(ir[10:0]), 2 = RF R1 data.
- `ir_ld`, `ir_clr` out 1: IR load and clear strobes.
- `mem_rd`, `mem_wr` out 1: memory read and write strobes.
- `mem_r_addr_sel` out 2: read address. 0 = PC, 1 = PC+sext9, 2 = R0 data, 3 = R1+sext6.
- `mem_w_addr_sel` out 2: write address. 0 = PC+sext9, 1 = prev, 2 = R1+sext6.
- `rf_w_data_sel` out 2: RF write data. 0 = ALU, 1 = PC+sext9, 2 = memory read data, 3 = PC.
- `rf_w_addr_sel` out 1: RF write address. 0 = R7, 1 = ir[11:9].
- `rf_w_wr` out 1: RF write enable.
- `rf_r0_addr_sel` out 1: R0 read address. 0 = ir[11:9], 1 = ir[2:0].
- `rf_r0_rd`, `rf_r1_rd` out 1: RF read strobes.
- `prev_ld` out 1: load the prev register from memory read data.
- `nzp_ld`, `nzp_clr` out 1: condition-code load and clear.
- `alu_sel` out 2: ALU operation. 0 = PassA, 1 = ADD, 2 = AND, 3 = NOT.
- `alu_first_val_sel` out 1: ALU first operand. 0 = sext(ir[4:0]), 1 = R0 data.
- `halted` out 1: high while in HALT.
- `state_debug` out 3: current state encoding.

## Operation
- States: INIT=0, FETCH=1, EXEC=2, EXEC2=3, HALT=4. Codes 5–7 go to INIT on the next edge.
- All outputs are combinational from the state and `ir`.
- Every strobe defaults to 0 and every select defaults to 0.
- INIT: assert `pc_clr`, `ir_clr`, `nzp_clr`. Next state is FETCH.
- FETCH: assert `mem_rd`, `mem_r_addr_sel=0`, `ir_ld`, `pc_inc`. Next state is EXEC.
- EXEC, by opcode `ir[15:12]`:
  - ADD 0001 / AND 0101:
    - Assert `rf_r1_rd` and `rf_w_wr`; `rf_w_addr_sel=1`, `rf_w_data_sel=0`.
    - `alu_sel` = 1 for ADD, 2 for AND.
    - `alu_first_val_sel=~ir[5]`, `rf_r0_addr_sel=1`, `rf_r0_rd=~ir[5]`.
    - Assert `nzp_ld`.
  - NOT 1001: `alu_sel=3`, `rf_r1_rd`, `rf_w_wr`, `rf_w_addr_sel=1`, `rf_w_data_sel=0`, `nzp_ld`.
  - BR 0000: assert `pc_ld` with `pc_sel=0` only if `nzp_true`.
  - JMP 1100: `rf_r1_rd`, `pc_ld`, `pc_sel=2`.
  - JSR 0100:
    - Write R7: `rf_w_wr`, `rf_w_addr_sel=0`, `rf_w_data_sel=3`.
    - Same cycle: `pc_ld` with `pc_sel = ir[11] ? 1 : 2`; `rf_r1_rd` when `ir[11]=0`.
    - The RF write and the PC load land on the same edge, so the old PC and old R7 are used.
  - LD 0010: `mem_rd`, `mem_r_addr_sel=1`, `rf_w_wr`, `rf_w_addr_sel=1`, `rf_w_data_sel=2`, `nzp_ld`.
  - LDR 0110: as LD but `mem_r_addr_sel=3`, plus `rf_r1_rd`.
  - LEA 1110: `rf_w_wr`, `rf_w_addr_sel=1`, `rf_w_data_sel=1`. `nzp_ld` per Configuration.
  - ST 0011: `mem_wr`, `mem_w_addr_sel=0`, `rf_r0_addr_sel=0`, `rf_r0_rd`.
  - STR 0111: as ST but `mem_w_addr_sel=2`, plus `rf_r1_rd`.
  - LDI 1010: write DR with mem[PC+sext9] (`mem_rd`, `mem_r_addr_sel=1`, `rf_w_wr`, `rf_w_addr_sel=1`, `rf_w_data_sel=2`). No `nzp_ld`. Next state is EXEC2.
  - STI 1011: `mem_rd`, `mem_r_addr_sel=1`, `prev_ld`. Next state is EXEC2.
  - HALT 1111: no strobes. Next state is HALT.
  - RTI 1000 / reserved 1101: no strobes (NOP).
  - All other EXEC cases: next state is FETCH.
- EXEC2:
  - LDI: `rf_r0_addr_sel=0`, `rf_r0_rd`, `mem_rd`, `mem_r_addr_sel=2`, `rf_w_wr`, `rf_w_addr_sel=1`, `rf_w_data_sel=2`, `nzp_ld`.
  - STI: `mem_wr`, `mem_w_addr_sel=1`, `rf_r0_addr_sel=0`, `rf_r0_rd`.
  - Next state is FETCH.
- HALT: no strobes, `halted=1`. Self-loop; only `rst` exits.
- Invariants:
  - `pc_inc` and `pc_ld` are never asserted together (the datapath gives `pc_inc` priority).
  - `mem_wr` and `rf_w_wr` are never asserted together.

## Timing
- While `rst` is high, the state is INIT, so `pc_clr=ir_clr=nzp_clr=1` and all other outputs are 0.
- First edge after `rst` falls: the datapath clears and the state goes to FETCH.
- Instruction latency:
  - 2 cycles (FETCH + EXEC) for most opcodes.
  - 3 cycles for LDI/STI.
  - First fetch occurs 1 cycle after reset release.
- `rst` asserted in any state forces INIT immediately, with no edge required. An interrupted EXEC2 write is abandoned.
- `nzp_true` and `ir` are sampled combinationally in EXEC. IR is stable there because it was loaded at the FETCH edge.

## Configuration
- `PUNC_LEA_CC_EN` defined: LEA asserts `nzp_ld` in EXEC (classic LC3; CC reflects the computed address).
- Undefined: LEA never touches NZP.

## Test plan
- Release `rst` with memory[0]=0xF025 (HALT):
  - `state_debug` goes 0→1→2→4.
  - `halted=1` from cycle 3 onward; PC=1.
- ADD R1,R1,#-1 (0x127F) with R1=0 -> R1=0xFFFF, N=1; EXEC shows `alu_first_val_sel=0`, `nzp_ld=1`.
- BRz +2 (0x0402):
  - With Z=1: PC goes from 1 to 3.
  - With Z=0: PC stays at 1 and `pc_ld=0` during EXEC.
- JSR +4 (0x4804) at address 0x10 -> R7=0x11, PC=0x15; `pc_inc` and `pc_ld` are never both high.
- LDI R2 (0xA4xx) with pointer=0x30 and mem[0x30]=0x8000:
  - 3 cycles total; R2=0x8000, N=1.
  - STI to the same pointer writes R3's value to mem[0x30].
- Assert `rst` mid-EXEC2 of STI -> outputs go to INIT values asynchronously, no `mem_wr` edge occurs, and execution restarts from PC=0.
